// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle RV32 subset control unit:
// opcode constants, ALU control codes, ALUOp codes and the FSM state set.
package multicycle_control_pkg;

    // RV32 major opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation codes seen by the datapath ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // Coarse ALU request from the FSM, refined by the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_RFUNCT,
        ALUOP_IFUNCT
    } alu_op_e;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC_R,
        EXEC_I,
        ALUWB,
        BRANCH,
        HALT
    } state_e;

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU decoder: maps the FSM's ALUOp request plus funct3/funct7[5] to the
// 4-bit ALU control code, and flags funct combinations the datapath cannot do.
// Ports:
//   i_alu_op        ALUOp request (ADD, SUB, RFUNCT, IFUNCT)
//   i_funct3        IR[14:12]
//   i_funct7_5      IR[30]
//   o_alu_control   ALU operation code
//   o_funct_valid   1 when the funct fields name a supported operation
module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  alu_op_e     i_alu_op,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    output logic [3:0]  o_alu_control,
    output logic        o_funct_valid
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_funct_valid = 1'b1;
        unique case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_RFUNCT: begin
                case ({i_funct7_5, i_funct3})
                    4'b0_000: o_alu_control = ALU_ADD;
                    4'b1_000: o_alu_control = ALU_SUB;
                    4'b0_111: o_alu_control = ALU_AND;
                    4'b0_110: o_alu_control = ALU_OR;
                    default:  o_funct_valid = 1'b0;
                endcase
            end
            ALUOP_IFUNCT: begin
                // IR[30] is immediate data for I-type, so it is ignored here
                case (i_funct3)
                    3'b000:  o_alu_control = ALU_ADD;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_funct_valid = 1'b0;
                endcase
            end
            default: o_funct_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32 subset datapath. Moore-decodes every
// datapath enable/select and the ALU control code from the current state; only
// PCWrite in BRANCH follows the ALU zero flag.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_opcode, i_funct3,   IR fields (IR[6:0], IR[14:12], IR[30])
//   i_funct7_5
//   i_zero                ALU zero flag
//   o_pc_write ... o_reg_write   datapath enables and mux selects
//   o_alu_control         ALU operation code
//   o_instr_done          pulse in the last cycle of each instruction
//   o_illegal             high while parked in HALT
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic        i_funct7_5,
    input  logic        i_zero,
    output logic        o_pc_write,
    output logic        o_iord,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_ir_write,
    output logic        o_mem_to_reg,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic        o_pc_source,
    output logic        o_reg_write,
    output logic [3:0]  o_alu_control,
    output logic        o_instr_done,
    output logic        o_illegal
);

    state_e     r_state;
    state_e     w_state_next;
    alu_op_e    w_alu_op;
    logic [3:0] w_dec_ctl;
    logic       w_dec_valid;
    logic       w_legal;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // In DECODE the decoder is pointed at the instruction's funct class so its
    // valid flag doubles as the legality check; its control code is unused there.
    always_comb begin
        w_alu_op = ALUOP_ADD;
        case (r_state)
            DECODE: begin
                if (i_opcode == OP_RTYPE) begin
                    w_alu_op = ALUOP_RFUNCT;
                end else if (i_opcode == OP_ITYPE) begin
                    w_alu_op = ALUOP_IFUNCT;
                end
            end
            EXEC_R:  w_alu_op = ALUOP_RFUNCT;
            EXEC_I:  w_alu_op = ALUOP_IFUNCT;
            BRANCH:  w_alu_op = ALUOP_SUB;
            default: w_alu_op = ALUOP_ADD;
        endcase
    end

    multicycle_control_alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (i_funct3),
        .i_funct7_5    (i_funct7_5),
        .o_alu_control (w_dec_ctl),
        .o_funct_valid (w_dec_valid)
    );

    always_comb begin
        w_state_next  = r_state;
        o_pc_write    = 1'b0;
        o_iord        = 1'b0;
        o_mem_read    = 1'b0;
        o_mem_write   = 1'b0;
        o_ir_write    = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_alu_src_a   = 1'b0;
        o_alu_src_b   = 2'b00;
        o_pc_source   = 1'b0;
        o_reg_write   = 1'b0;
        o_alu_control = ALU_ADD;
        o_instr_done  = 1'b0;
        o_illegal     = 1'b0;

        // Only meaningful in DECODE, where w_dec_valid checks the funct class
        case (i_opcode)
            OP_LOAD, OP_STORE:  w_legal = 1'b1;
            OP_RTYPE, OP_ITYPE: w_legal = w_dec_valid;
            OP_BRANCH:          w_legal = (i_funct3 == 3'b000);
            default:            w_legal = 1'b0;
        endcase

        // Reset forces the idle output pattern even though the state is FETCH
        if (i_rst_n) begin
            case (r_state)
                FETCH: begin
                    o_mem_read   = 1'b1;
                    o_ir_write   = 1'b1;
                    o_alu_src_b  = 2'b01;
                    w_state_next = DECODE;
                end
                DECODE: begin
                    o_alu_src_b = 2'b10;
                    o_pc_write  = 1'b1;
                    o_pc_source = 1'b1;
                    if (!w_legal) begin
                        if (ILLEGAL_HALT) begin
                            w_state_next = HALT;
                        end else begin
                            w_state_next = FETCH;
                        end
                    end else begin
                        case (i_opcode)
                            OP_LOAD, OP_STORE: w_state_next = MEMADR;
                            OP_RTYPE:          w_state_next = EXEC_R;
                            OP_ITYPE:          w_state_next = EXEC_I;
                            default:           w_state_next = BRANCH;
                        endcase
                    end
                end
                MEMADR: begin
                    o_alu_src_a  = 1'b1;
                    o_alu_src_b  = 2'b10;
                    w_state_next = (i_opcode == OP_LOAD) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    o_iord       = 1'b1;
                    o_mem_read   = 1'b1;
                    w_state_next = MEMWB;
                end
                MEMWB: begin
                    o_reg_write  = 1'b1;
                    o_mem_to_reg = 1'b1;
                    o_instr_done = 1'b1;
                    w_state_next = FETCH;
                end
                MEMWR: begin
                    o_iord       = 1'b1;
                    o_mem_write  = 1'b1;
                    o_instr_done = 1'b1;
                    w_state_next = FETCH;
                end
                EXEC_R: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_src_b   = 2'b00;
                    o_alu_control = w_dec_ctl;
                    w_state_next  = ALUWB;
                end
                EXEC_I: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_src_b   = 2'b10;
                    o_alu_control = w_dec_ctl;
                    w_state_next  = ALUWB;
                end
                ALUWB: begin
                    o_reg_write  = 1'b1;
                    o_instr_done = 1'b1;
                    w_state_next = FETCH;
                end
                BRANCH: begin
                    o_alu_src_a   = 1'b1;
                    o_alu_src_b   = 2'b00;
                    o_alu_control = w_dec_ctl;
                    o_pc_source   = 1'b1;
                    o_pc_write    = i_zero;
                    o_instr_done  = 1'b1;
                    w_state_next  = FETCH;
                end
                HALT: begin
                    o_illegal    = 1'b1;
                    w_state_next = HALT;
                end
                default: w_state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;
    // Output vector: {pcw,iord,mr,mw,irw,m2r,srcA,srcB[1:0],pcsrc,rw,ctl[3:0],done,illegal}
    localparam logic [16:0] RST_VEC = {11'b0, 4'b0010, 2'b00};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    bit         zero_rand = 1'b1;
    int         n_checks = 0;
    int         n_pass = 0;

    logic h_pcw, h_iord, h_mr, h_mw, h_irw, h_m2r, h_sa, h_ps, h_rw, h_done, h_ill;
    logic n_pcw, n_iord, n_mr, n_mw, n_irw, n_m2r, n_sa, n_ps, n_rw, n_done, n_ill;
    logic [1:0] h_sb, n_sb;
    logic [3:0] h_ctl, n_ctl;
    logic [16:0] obs_h, obs_n;

    always #5 clk = ~clk;

    multicycle_control #(.ILLEGAL_HALT(1'b1)) dut_h (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3),
        .i_funct7_5(funct7_5), .i_zero(zero), .o_pc_write(h_pcw), .o_iord(h_iord),
        .o_mem_read(h_mr), .o_mem_write(h_mw), .o_ir_write(h_irw), .o_mem_to_reg(h_m2r),
        .o_alu_src_a(h_sa), .o_alu_src_b(h_sb), .o_pc_source(h_ps), .o_reg_write(h_rw),
        .o_alu_control(h_ctl), .o_instr_done(h_done), .o_illegal(h_ill)
    );

    multicycle_control #(.ILLEGAL_HALT(1'b0)) dut_n (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3),
        .i_funct7_5(funct7_5), .i_zero(zero), .o_pc_write(n_pcw), .o_iord(n_iord),
        .o_mem_read(n_mr), .o_mem_write(n_mw), .o_ir_write(n_irw), .o_mem_to_reg(n_m2r),
        .o_alu_src_a(n_sa), .o_alu_src_b(n_sb), .o_pc_source(n_ps), .o_reg_write(n_rw),
        .o_alu_control(n_ctl), .o_instr_done(n_done), .o_illegal(n_ill)
    );

    assign obs_h = {h_pcw, h_iord, h_mr, h_mw, h_irw, h_m2r, h_sa, h_sb, h_ps, h_rw,
                    h_ctl, h_done, h_ill};
    assign obs_n = {n_pcw, n_iord, n_mr, n_mw, n_irw, n_m2r, n_sa, n_sb, n_ps, n_rw,
                    n_ctl, n_done, n_ill};

    // ---------------- reference model ----------------
    function automatic bit is_legal(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        logic [3:0] rf;
        rf = {f7, f3};
        case (op)
            LW, SW:  return 1'b1;
            RT:      return (rf == 4'b0000) || (rf == 4'b1000) || (rf == 4'b0111) || (rf == 4'b0110);
            IT:      return (f3 == 3'b000) || (f3 == 3'b110) || (f3 == 3'b111);
            BEQ:     return f3 == 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int instr_len(input logic [6:0] op);
        case (op)
            LW:      return 5;
            SW:      return 4;
            RT, IT:  return 4;
            BEQ:     return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [3:0] logic_ctl(input logic [2:0] f3);
        if (f3 == 3'b111) return 4'b0000;
        if (f3 == 3'b110) return 4'b0001;
        return 4'b0010;
    endfunction

    // Expected outputs in cycle k (0 = fetch cycle) of an instruction.
    function automatic logic [16:0] model_out(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7, input logic z, input int k);
        logic pcw, iord, mr, mw, irw, m2r, sa, ps, rw, done, ill;
        logic [1:0] sb;
        logic [3:0] ctl;
        {pcw, iord, mr, mw, irw, m2r, sa, ps, rw, done, ill} = '0;
        sb  = 2'b00;
        ctl = 4'b0010;
        if (k == 0) begin
            mr = 1'b1; irw = 1'b1; sb = 2'b01;
        end else if (k == 1) begin
            pcw = 1'b1; ps = 1'b1; sb = 2'b10;
        end else if (!is_legal(op, f3, f7)) begin
            ill = 1'b1;
        end else begin
            case (op)
                LW: begin
                    if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                    else if (k == 3) begin iord = 1'b1; mr = 1'b1; end
                    else begin rw = 1'b1; m2r = 1'b1; done = 1'b1; end
                end
                SW: begin
                    if (k == 2) begin sa = 1'b1; sb = 2'b10; end
                    else begin iord = 1'b1; mw = 1'b1; done = 1'b1; end
                end
                RT: begin
                    if (k == 2) begin sa = 1'b1; ctl = f7 ? 4'b0110 : logic_ctl(f3); end
                    else begin rw = 1'b1; done = 1'b1; end
                end
                IT: begin
                    if (k == 2) begin sa = 1'b1; sb = 2'b10; ctl = logic_ctl(f3); end
                    else begin rw = 1'b1; done = 1'b1; end
                end
                default: begin
                    sa = 1'b1; ctl = 4'b0110; ps = 1'b1; pcw = z; done = 1'b1;
                end
            endcase
        end
        return {pcw, iord, mr, mw, irw, m2r, sa, sb, ps, rw, ctl, done, ill};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode = op; funct3 = f3; funct7_5 = f7;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (zero_rand) zero = 1'($urandom_range(0, 1));
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [16:0] exp;
        set_instr(LW, 3'b010, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_h !== RST_VEC) $display("FAIL reset_hold cyc%0d: got %h want %h", i, obs_h, RST_VEC);
            else n_pass++;
            n_checks++;
            if (obs_n !== RST_VEC) $display("FAIL reset_hold_n cyc%0d: got %h want %h", i, obs_n, RST_VEC);
            else n_pass++;
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp = model_out(opcode, funct3, funct7_5, zero, k);
            n_checks++;
            if (obs_h !== exp) $display("FAIL post_reset k%0d: got %h want %h", k, obs_h, exp);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_load();
        logic [16:0] exp;
        int dones = 0;
        set_instr(LW, 3'b010, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp = model_out(opcode, funct3, funct7_5, zero, k);
            if (h_done) dones++;
            n_checks++;
            if (obs_h !== exp) $display("FAIL load k%0d: got %h want %h", k, obs_h, exp);
            else n_pass++;
            next_cycle();
        end
        n_checks++;
        if (dones !== 1) $display("FAIL load_done_pulses: got %0d want 1", dones);
        else n_pass++;
    endtask

    task automatic test_store();
        logic [16:0] exp;
        set_instr(SW, 3'b010, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp = model_out(opcode, funct3, funct7_5, zero, k);
            n_checks++;
            if (obs_h !== exp) $display("FAIL store k%0d: got %h want %h", k, obs_h, exp);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_alu_ops();
        logic [16:0] exp;
        logic [3:0] rf [4] = '{4'b1000, 4'b0111, 4'b0000, 4'b0110};
        logic [2:0] itf [3] = '{3'b000, 3'b110, 3'b111};
        for (int v = 0; v < 7; v++) begin
            if (v < 4) set_instr(RT, rf[v][2:0], rf[v][3]);
            else set_instr(IT, itf[v-4], 1'($urandom_range(0, 1)));
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                exp = model_out(opcode, funct3, funct7_5, zero, k);
                n_checks++;
                if (obs_h !== exp)
                    $display("FAIL alu_op op=%b f7=%b f3=%b k%0d: got %h want %h",
                             opcode, funct7_5, funct3, k, obs_h, exp);
                else n_pass++;
                next_cycle();
            end
        end
    endtask

    task automatic test_branch();
        logic [16:0] exp;
        zero_rand = 1'b0;
        for (int z = 1; z >= 0; z--) begin
            zero = 1'(z);
            set_instr(BEQ, 3'b000, 1'b0);
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                exp = model_out(opcode, funct3, funct7_5, zero, k);
                n_checks++;
                if (obs_h !== exp) $display("FAIL branch z=%0d k%0d: got %h want %h", z, k, obs_h, exp);
                else n_pass++;
                next_cycle();
            end
        end
        zero_rand = 1'b1;
    endtask

    task automatic test_halt();
        logic [16:0] exp;
        set_instr(RT, 3'b111, 1'b1);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            exp = model_out(opcode, funct3, funct7_5, zero, k);
            n_checks++;
            if (obs_h !== exp) $display("FAIL halt k%0d: got %h want %h", k, obs_h, exp);
            else n_pass++;
            next_cycle();
        end
        apply_reset();
        set_instr(SW, 3'b010, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp = model_out(opcode, funct3, funct7_5, zero, k);
            n_checks++;
            if (obs_h !== exp) $display("FAIL halt_exit k%0d: got %h want %h", k, obs_h, exp);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] exp;
        set_instr(LW, 3'b010, 1'b0);
        for (int k = 0; k < 3; k++) next_cycle();
        // now inside MEMRD; reset lands between clock edges
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_h !== RST_VEC) $display("FAIL reset_async: got %h want %h", obs_h, RST_VEC);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (obs_h !== RST_VEC) $display("FAIL reset_mid_hold: got %h want %h", obs_h, RST_VEC);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp = model_out(opcode, funct3, funct7_5, zero, k);
            n_checks++;
            if (obs_h !== exp) $display("FAIL reset_mid_restart k%0d: got %h want %h", k, obs_h, exp);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_nop();
        logic [16:0] exp;
        apply_reset();
        for (int r = 0; r < 4; r++) begin
            if (r < 3) set_instr(BAD, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            else set_instr(LW, 3'b010, 1'b0);
            for (int k = 0; k < instr_len(opcode); k++) begin
                @(negedge clk);
                exp = model_out(opcode, funct3, funct7_5, zero, k);
                n_checks++;
                if (obs_n !== exp) $display("FAIL nop r%0d k%0d: got %h want %h", r, k, obs_n, exp);
                else n_pass++;
                next_cycle();
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] exp;
        logic [6:0] ops [5] = '{LW, SW, RT, IT, BEQ};
        bit legal;
        int len;
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            int idx = $urandom_range(0, 5);
            set_instr((idx == 5) ? 7'($urandom) : ops[idx], 3'($urandom), 1'($urandom));
            legal = is_legal(opcode, funct3, funct7_5);
            len = legal ? instr_len(opcode) : 5;
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                exp = model_out(opcode, funct3, funct7_5, zero, k);
                n_checks++;
                if (obs_h !== exp)
                    $display("FAIL random n%0d op=%b f3=%b f7=%b k%0d: got %h want %h",
                             n, opcode, funct3, funct7_5, k, obs_h, exp);
                else n_pass++;
                if (legal || k < 2) begin
                    n_checks++;
                    if (obs_n !== exp)
                        $display("FAIL random_n n%0d k%0d: got %h want %h", n, k, obs_n, exp);
                    else n_pass++;
                end
                next_cycle();
            end
            if (!legal) apply_reset();
        end
    endtask

    initial begin
        rst_n = 1'b1;
        zero = 1'b0;
        set_instr(LW, 3'b010, 1'b0);
        test_reset();
        test_load();
        test_store();
        test_alu_ops();
        test_branch();
        test_halt();
        test_reset_mid();
        test_nop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32 subset datapath (PC, IR, MDR, A, B, ALUOut, mux set, ALU).
- Sits upstream of the datapath. Consumes IR opcode/funct fields and the ALU zero flag.
- Drives every datapath enable and mux select, plus the 4-bit ALU control code, each cycle.
- Supported instructions: lw, sw, add/sub/and/or (R-type), addi/ori/andi, beq.

Parameters:
- ILLEGAL_HALT, 1: 1 = illegal instruction parks the FSM in HALT; 0 = treated as NOP, FSM returns to FETCH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- opcode  input  7  IR[6:0]
- funct3  input  3  IR[14:12]
- funct7_5  input  1  IR[30]
- zero  input  1  ALU zero flag
- PCWrite  output  1  PC load enable (unconditional OR branch-taken)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read enable
- MemWrite  output  1  memory write enable
- IRWrite  output  1  IR load enable
- MemtoReg  output  1  writeback select: 1 = MDR, 0 = ALUOut
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = imm
- PCSource  output  1  PC source: 1 = ALUOut, 0 = ALU result
- RegWrite  output  1  register file write enable
- ALUControl  output  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB
- instr_done  output  1  one-cycle pulse in the last cycle of each instruction
- illegal  output  1  high while the FSM is in HALT

Behaviour:
- State register is reset asynchronously to FETCH when reset = 0.
- While reset = 0, all enables and all selects are 0, ALUControl = 0010, and instr_done = illegal = 0.
- Reset mid-instruction aborts the instruction immediately; there is no partial retire.
- Outputs are Moore-decoded from state, except PCWrite in BRANCH, which equals zero.
- Any signal not listed for a state is 0.
- FETCH: MemRead, IorD = 0, IRWrite, ALUSrcA = 0, ALUSrcB = 01, ADD. ALUOut captures PC+4. Next: DECODE.
- DECODE: ALUSrcA = 0, ALUSrcB = 10, ADD, PCWrite, PCSource = 1.
  - PC <= PC+4 and ALUOut <= old PC + imm (branch target) on the same edge; A/B capture rs1/rs2.
  - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH.
  - Anything else, or an unsupported funct combination -> HALT (ILLEGAL_HALT = 1) or FETCH (ILLEGAL_HALT = 0).
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ADD. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: IorD = 1, MemRead. MDR captures the load data. Next: MEMWB.
- MEMWB: RegWrite, MemtoReg = 1, instr_done. Next: FETCH.
- MEMWR: IorD = 1, MemWrite, instr_done. Next: FETCH.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00. ALUControl decoded from {funct7_5, funct3}:
  - 0/000 ADD, 1/000 SUB, 0/111 AND, 0/110 OR. Next: ALUWB.
- EXEC_I: ALUSrcA = 1, ALUSrcB = 10. funct3: 000 ADD, 110 OR, 111 AND. Next: ALUWB.
- ALUWB: RegWrite, MemtoReg = 0, instr_done. Next: FETCH.
- BRANCH (beq only, funct3 = 000): ALUSrcA = 1, ALUSrcB = 00, SUB, PCSource = 1, PCWrite = zero, instr_done. Next: FETCH.
- HALT: illegal = 1, all enables 0. Left only by reset.
- Cycle counts: lw 5, sw 4, R-type 4, I-type 4, beq 3, illegal NOP 2.
- The illegal check uses IR fields during DECODE only; IR is stable from the end of FETCH until the next FETCH.

Decomposition:
- Shared package holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH);
  - ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB);
  - 2-bit ALUOp codes (ADD, SUB, RFUNCT, IFUNCT);
  - the state enumeration (FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R, EXEC_I, ALUWB, BRANCH, HALT).
- Sub-module alu_decoder: combinational ALUOp + funct3 + funct7_5 -> ALUControl plus a funct_valid flag, reused by the DECODE legality check.

Test Plan:
- Reset low for 3 cycles, then release -> all outputs 0 during reset; first cycle after release is FETCH with MemRead = IRWrite = 1, ALUSrcB = 01; DECODE follows with PCWrite = 1, PCSource = 1.
- opcode 0000011 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite = MemtoReg = 1 only in cycle 5; instr_done pulses once.
- opcode 0100011 -> MEMWR in cycle 4 with IorD = 1, MemWrite = 1, RegWrite = 0.
- opcode 0110011 with funct7_5 = 1, funct3 = 000 -> ALUControl = 0110 in EXEC_R; with funct3 = 111 -> 0000; with funct7_5 = 1, funct3 = 111 -> HALT, illegal = 1, held until reset.
- opcode 1100011 with zero = 1 in BRANCH -> PCWrite = 1, PCSource = 1; with zero = 0 -> PCWrite = 0; FETCH follows in both cases.
- Reset asserted during MEMRD -> state is FETCH and outputs are 0 immediately (asynchronously), with no RegWrite or instr_done; ILLEGAL_HALT = 0 with opcode 1111111 -> FETCH, DECODE, FETCH.
